vote_machine_n: RTL and testbench

Parametrised N-candidate successor to the fixed four-button voting machine. It qualifies raw candidate buttons and rejects simultaneous presses. It enforces a post-vote lockout, keeps saturating per-candidate tallies, and drives a shared LED bus in either voting (acknowledge) or result (per-candidate count) mode. It sits at the top of the voting datapath, directly between board buttons/switches and the LED bank.

---
 rtl/vote_pkg.sv | 17 +
 rtl/press_qualifier.sv | 43 ++++
 rtl/vote_machine_n.sv | 190 +++++++++++++++++++
 tb/tb_vote_machine_n.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the N-candidate voting machine.
package vote_pkg;

  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } lock_state_t;

  // Candidate-index width; a single bit is the floor so ports never collapse.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/press_qualifier.sv
// Single-button press qualifier: one-cycle qual on the PRESS_CYC-th consecutive
// high sample, then stays quiet until the button is sampled low.
module press_qualifier #(
  parameter int unsigned PRESS_CYC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic button,
  output logic qual
);

  localparam int unsigned CW = $clog2(PRESS_CYC);

  logic [CW-1:0] r_cnt;
  logic          r_hold;
  logic          r_qual;

  // r_hold comes out of reset set so a button held through reset must be released first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_hold <= 1'b1;
      r_qual <= 1'b0;
    end else if (!en || !button) begin
      r_cnt  <= '0;
      r_hold <= 1'b0;
      r_qual <= 1'b0;
    end else if (r_hold) begin
      r_qual <= 1'b0;
    end else if (r_cnt == CW'(PRESS_CYC - 1)) begin
      r_cnt  <= '0;
      r_hold <= 1'b1;
      r_qual <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_qual <= 1'b0;
    end
  end

  assign qual = r_qual;

endmodule

// File: rtl/vote_machine_n.sv
// N-candidate voting machine: press qualification, arbitration, lockout,
// saturating tallies and LED mux. Winner/tie logic needs VOTE_MACHINE_WINNER_EN.
module vote_machine_n
  import vote_pkg::*;
#(
  parameter int unsigned NUM_CAND  = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PRESS_CYC = 10,
  parameter int unsigned ACK_CYC   = 100
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 mode,
  input  logic [NUM_CAND-1:0]                  button,
  input  logic [vote_pkg::sel_w(NUM_CAND)-1:0] sel,
  output logic [CNT_W-1:0]                     led,
  output logic                                 vote_ok,
  output logic                                 conflict,
  output logic [NUM_CAND-1:0]                  sat,
  output logic [vote_pkg::sel_w(NUM_CAND)-1:0] winner,
  output logic                                 tie
);

  localparam int unsigned SEL_W = sel_w(NUM_CAND);
  localparam int unsigned ACK_W = (ACK_CYC > 1) ? $clog2(ACK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CAND-1:0] w_qual;
  logic                w_en;
  logic                w_single;
  logic                w_multi;
  logic                w_accept;
  logic                w_conflict;
  lock_state_t         r_state;
  lock_state_t         w_state_nxt;
  logic [ACK_W-1:0]    r_ack_cnt;
  logic [ACK_W-1:0]    w_ack_nxt;
  logic [CNT_W-1:0]    r_tally     [NUM_CAND];
  logic [CNT_W-1:0]    w_tally_nxt [NUM_CAND];
  logic [CNT_W-1:0]    r_led;
  logic [CNT_W-1:0]    w_led_nxt;
  logic [NUM_CAND-1:0] r_sat;
  logic                r_vote_ok;
  logic                r_conflict;

  assign w_en     = (mode == MODE_VOTE);
  assign w_single = ($countones(w_qual) == 1);
  assign w_multi  = ($countones(w_qual) > 1);

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_qual
    press_qualifier #(.PRESS_CYC(PRESS_CYC)) u_qual (
      .clk    (clk),
      .rst    (rst),
      .en     (w_en),
      .button (button[g]),
      .qual   (w_qual[g])
    );
  end

  // Lockout state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ack_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ack_cnt <= w_ack_nxt;
    end
  end

  // Arbitration and lockout next-state; quals arriving during ACK are dropped silently.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack_cnt;
    w_accept    = 1'b0;
    w_conflict  = 1'b0;
    if (mode == MODE_RESULT) begin
      w_state_nxt = IDLE;
      w_ack_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_single) begin
            w_accept    = 1'b1;
            w_state_nxt = ACK;
            w_ack_nxt   = '0;
          end else if (w_multi) begin
            w_conflict = 1'b1;
          end
        end
        ACK: begin
          if (r_ack_cnt == ACK_W'(ACK_CYC - 1)) begin
            w_state_nxt = IDLE;
            w_ack_nxt   = '0;
          end else begin
            w_ack_nxt = r_ack_cnt + ACK_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_ack_nxt   = '0;
        end
      endcase
    end
  end

  // Saturating tally update and LED source selection.
  always_comb begin
    for (int i = 0; i < NUM_CAND; i++) begin
      w_tally_nxt[i] = r_tally[i];
      if (w_accept && w_qual[i] && (r_tally[i] != CNT_MAX)) begin
        w_tally_nxt[i] = r_tally[i] + CNT_W'(1);
      end
    end
    w_led_nxt = '0;
    if (mode == MODE_RESULT) begin
      if (32'(sel) < NUM_CAND) begin
        w_led_nxt = r_tally[sel];
      end
    end else if (w_state_nxt == ACK) begin
      w_led_nxt = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        r_tally[i] <= '0;
      end
      r_sat      <= '0;
      r_led      <= '0;
      r_vote_ok  <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) begin
        r_tally[i] <= w_tally_nxt[i];
        r_sat[i]   <= &w_tally_nxt[i];
      end
      r_led      <= w_led_nxt;
      r_vote_ok  <= w_accept;
      r_conflict <= w_conflict;
    end
  end

  assign led      = r_led;
  assign vote_ok  = r_vote_ok;
  assign conflict = r_conflict;
  assign sat      = r_sat;

`ifdef VOTE_MACHINE_WINNER_EN
  logic [CNT_W-1:0] w_best;
  logic [SEL_W-1:0] w_win;
  logic             w_tie;
  logic [SEL_W-1:0] r_winner;
  logic             r_tie;

  // Linear max scan; strict '>' keeps the lowest index on equal tallies.
  always_comb begin
    w_best = r_tally[0];
    w_win  = '0;
    w_tie  = 1'b0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (r_tally[i] > w_best) begin
        w_best = r_tally[i];
        w_win  = SEL_W'(i);
        w_tie  = 1'b0;
      end else if (r_tally[i] == w_best) begin
        w_tie = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_winner <= '0;
      r_tie    <= 1'b0;
    end else begin
      r_winner <= w_win;
      r_tie    <= w_tie;
    end
  end

  assign winner = r_winner;
  assign tie    = r_tie;
`else
  assign winner = '0;
  assign tie    = 1'b0;
`endif

endmodule

// File: tb/tb_vote_machine_n.sv
// Directed bench for vote_machine_n: scoreboard of expected vote/conflict events
// plus result-mode tally readback, on a default instance and a 2-bit-tally instance.
module tb_vote_machine_n;

  localparam int P1 = 10;  // PRESS_CYC, main instance
  localparam int A1 = 100; // ACK_CYC, main instance
  localparam int P2 = 3;
  localparam int A2 = 4;

`ifdef VOTE_MACHINE_WINNER_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  typedef struct {
    int cyc;
    bit conf;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [1:0] sel;
  logic [3:0] btn, btn2;
  logic [7:0] led;
  logic [1:0] led2;
  logic       vote_ok, vote_ok2, conflict, conflict2, tie, tie2;
  logic [3:0] sat, sat2;
  logic [1:0] winner, winner2;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  ev_t  q1[$];
  ev_t  q2[$];

  vote_machine_n #(.NUM_CAND(4), .CNT_W(8), .PRESS_CYC(P1), .ACK_CYC(A1)) dut (
    .clk(clk), .rst(rst), .mode(mode), .button(btn), .sel(sel), .led(led),
    .vote_ok(vote_ok), .conflict(conflict), .sat(sat), .winner(winner), .tie(tie)
  );

  vote_machine_n #(.NUM_CAND(4), .CNT_W(2), .PRESS_CYC(P2), .ACK_CYC(A2)) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .button(btn2), .sel(sel), .led(led2),
    .vote_ok(vote_ok2), .conflict(conflict2), .sat(sat2), .winner(winner2), .tie(tie2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event monitor, main instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (vote_ok || conflict) begin
        if (q1.size() == 0) begin
          check("spurious_evt", 32'({vote_ok, conflict}), 32'd0);
        end else begin
          ev_t e;
          e = q1.pop_front();
          check("evt_cycle", 32'(cyc), 32'(e.cyc));
          check("evt_kind", 32'({vote_ok, conflict}), e.conf ? 32'd1 : 32'd2);
          check(vote_ok ? "ack_led" : "conf_led", 32'(led), vote_ok ? 32'hFF : 32'h0);
        end
      end
      if (q1.size() != 0 && cyc > q1[0].cyc) begin
        check("evt_missing", 32'(cyc), 32'(q1[0].cyc));
        void'(q1.pop_front());
      end
    end
  end

  // Event monitor, 2-bit-tally instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (vote_ok2 || conflict2) begin
        if (q2.size() == 0) begin
          check("spurious_evt2", 32'({vote_ok2, conflict2}), 32'd0);
        end else begin
          ev_t e;
          e = q2.pop_front();
          check("evt2_cycle", 32'(cyc), 32'(e.cyc));
          check("evt2_kind", 32'({vote_ok2, conflict2}), e.conf ? 32'd1 : 32'd2);
          if (vote_ok2) check("ack_led2", 32'(led2), 32'h3);
        end
      end
      if (q2.size() != 0 && cyc > q2[0].cyc) begin
        check("evt2_missing", 32'(cyc), 32'(q2[0].cyc));
        void'(q2.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // kind: 0 = no event expected, 1 = vote, 2 = conflict
  task automatic press(input logic [3:0] m, input int hold, input int kind);
    ev_t e;
    if (kind != 0) begin
      e.cyc  = cyc + P1 + 1;
      e.conf = (kind == 2);
      q1.push_back(e);
    end
    btn = m;
    repeat (hold) @(negedge clk);
    btn = '0;
  endtask

  task automatic vote1(input logic [3:0] m);
    press(m, 12, 1);
    wait_cyc(A1);
  endtask

  task automatic vote2(input logic [3:0] m);
    ev_t e;
    e.cyc  = cyc + P2 + 1;
    e.conf = 1'b0;
    q2.push_back(e);
    btn2 = m;
    repeat (P2) @(negedge clk);
    btn2 = '0;
    wait_cyc(A2 + 2);
  endtask

  task automatic chk_tally(input int idx, input int exp);
    mode = 1'b1;
    sel  = 2'(idx);
    @(negedge clk);
    check($sformatf("tally%0d", idx), 32'(led), 32'(exp));
    mode = 1'b0;
    @(negedge clk);
  endtask

  int c;

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; btn = '0; btn2 = '0;
    wait_cyc(3);
    check("rst_led", 32'(led), 0);
    check("rst_outs", 32'({vote_ok, conflict, sat, winner, tie}), 0);
    check("rst_led2", 32'({led2, sat2, tie2}), 0);
    rst = 1'b0;
    wait_cyc(2);
    check("tie_after_rst", 32'({winner, tie}), 32'(WEN));

    // Saturation on the 2-bit instance: the fourth vote still pulses vote_ok.
    for (int k = 0; k < 4; k++) vote2(4'b1000);
    check("sat2", 32'(sat2), 32'h8);
    check("sat_main", 32'(sat), 0);
    mode = 1'b1; sel = 2'd3;
    @(negedge clk);
    check("led2_result", 32'(led2), 3);
    check("led_result_main", 32'(led), 0);
    check("winner2", 32'({winner2, tie2}), WEN ? 32'h6 : 32'h0);
    mode = 1'b0;
    @(negedge clk);

    // Two short presses never qualify.
    press(4'b0010, 9, 0);
    @(negedge clk);
    press(4'b0010, 9, 0);
    wait_cyc(5);
    chk_tally(1, 0);
    check("tie_all_zero", 32'(tie), 32'(WEN));

    // Simultaneous presses: conflict, no vote, led stays 0.
    press(4'b1001, 12, 2);
    wait_cyc(3);
    check("led_after_conf", 32'(led), 0);
    chk_tally(0, 0);
    chk_tally(3, 0);

    // Single accepted vote for candidate 2 and exact ACK window.
    c = cyc;
    press(4'b0100, 15, 1);
    wait_until(c + P1 + A1);
    check("ack_last", 32'(led), 32'hFF);
    @(negedge clk);
    check("ack_over", 32'(led), 0);
    chk_tally(2, 1);
    check("winner_2", 32'({winner, tie}), WEN ? 32'h4 : 32'h0);

    // Re-press during ACK is dropped; after ACK it counts.
    c = cyc;
    press(4'b0010, 12, 1);
    wait_until(c + 31);
    press(4'b0010, 12, 0);
    wait_until(c + 115);
    press(4'b0010, 12, 1);
    wait_cyc(A1);
    chk_tally(1, 2);
    check("winner_1", 32'({winner, tie}), WEN ? 32'h2 : 32'h0);

    // Tallies {2,2,0,1}: lowest index wins the tie.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vote1(4'b0001); vote1(4'b0001);
    vote1(4'b0010); vote1(4'b0010);
    vote1(4'b1000);
    wait_cyc(2);
    check("winner_tie", 32'({winner, tie}), WEN ? 32'h1 : 32'h0);
    chk_tally(0, 2);
    chk_tally(3, 1);

    // Reset in the middle of ACK.
    press(4'b0100, 12, 1);
    wait_cyc(20);
    check("mid_ack_led", 32'(led), 32'hFF);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ack_led", 32'(led), 0);
    check("rst_ack_outs", 32'({vote_ok, conflict, sat, winner, tie}), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk_tally(i, 0);

    wait_cyc(5);
    check("q1_drained", 32'(q1.size()), 0);
    check("q2_drained", 32'(q2.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
